// File: rtl/gpu_op_scheduler_pkg.sv
// Shared GPU types plus the frame scheduler's state encoding and defaults.
package gpu_op_scheduler_pkg;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [11:0] arg;
    } gpu_op_t;

    typedef enum logic {
        SERVE = 1'b0,
        DONE  = 1'b1
    } sched_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

    // Index width that stays at least one bit for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpu_op_scheduler_stall_watchdog.sv
// Counts consecutive idle cycles of the served requester and flags expiry.
module stall_watchdog
    import gpu_op_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic ENABLED = (TIMEOUT_CYCLES > 0);

    logic [CW-1:0] count;

    // Expiry fires on the idle cycle that would bring the count to TIMEOUT_CYCLES.
    assign expire = ENABLED && tick && !clear && (count == LIMIT);

    always_ff @(posedge clk) begin
        if (rst || clear || expire) begin
            count <= '0;
        end else if (tick && ENABLED) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/gpu_op_scheduler.sv
// Frame scheduler: drains op producers in fixed order onto the single GPU op port.
// Handshake: a transfer happens on an edge where valid and ready are both high; valid never waits for ready.
module gpu_op_scheduler
    import gpu_op_scheduler_pkg::*;
#(
    parameter int REQUESTERS     = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int IW            = idx_width(REQUESTERS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce,
    input  logic                         swap,
    input  gpu_op_t [REQUESTERS-1:0]     req_op,
    input  logic    [REQUESTERS-1:0]     req_valid,
    input  logic    [REQUESTERS-1:0]     req_last,
    output logic    [REQUESTERS-1:0]     req_ready,
    output gpu_op_t                      op,
    output logic                         op_valid,
    input  logic                         op_ready,
    output logic                         frame_done,
    output logic                         overrun,
    output logic    [IW-1:0]             cur_req
);

    localparam logic [IW-1:0] LAST_IDX = IW'(REQUESTERS - 1);

    sched_state_t  state, state_n;
    logic [IW-1:0] cur_n;
    logic          ovr_n;

    logic    sel_valid;
    logic    sel_last;
    gpu_op_t sel_op;
    logic    serving;
    logic    accept;
    logic    advance;
    logic    wd_tick;
    logic    wd_clear;
    logic    wd_expire;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_op    = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (cur_req == IW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_op    = req_op[i];
            end
        end
    end

    assign serving  = (state == SERVE);
    assign accept   = op_valid && op_ready;
    // Any valid cycle (stalled by the GPU or not) proves the producer is alive.
    assign wd_tick  = serving && ce && !sel_valid;
    assign wd_clear = swap || (serving && ce && sel_valid);
    assign advance  = serving && ((accept && sel_last) || wd_expire);

    stall_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clear (wd_clear),
        .tick  (wd_tick),
        .expire(wd_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SERVE;
            cur_req <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            cur_req <= cur_n;
            overrun <= ovr_n;
        end
    end

    always_comb begin
        state_n = state;
        cur_n   = cur_req;
        ovr_n   = overrun;
        if (swap) begin
            state_n = SERVE;
            cur_n   = '0;
            ovr_n   = 1'b0;
        end else if (advance) begin
            if (cur_req == LAST_IDX) begin
                state_n = DONE;
            end else begin
                cur_n = cur_req + 1'b1;
            end
            if (wd_expire) begin
                ovr_n = 1'b1;
            end
        end
    end

    always_comb begin
        op         = sel_op;
        op_valid   = !rst && serving && ce && sel_valid;
        frame_done = (state == DONE);
        req_ready  = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (cur_req == IW'(i)) begin
                req_ready[i] = !rst && serving && ce && op_ready;
            end
        end
    end

endmodule

// File: tb/tb_gpu_op_scheduler.sv
// Randomized frame-level bench for gpu_op_scheduler against a queue-based frame model.
module tb_gpu_op_scheduler;
    import gpu_op_scheduler_pkg::*;

    localparam int R   = 2;
    localparam int T   = 8;
    localparam int MAXOPS = 8;
    localparam int SW  = 18;

    logic               clk = 1'b0;
    logic               rst, ce, swap, op_ready;
    gpu_op_t [R-1:0]    req_op;
    logic    [R-1:0]    req_valid, req_last;
    logic    [R-1:0]    req_ready, req_ready2;
    gpu_op_t            op, op2;
    logic               op_valid, op_valid2;
    logic               frame_done, frame_done2;
    logic               overrun, overrun2;
    logic    [0:0]      cur_req, cur_req2;

    gpu_op_scheduler #(.REQUESTERS(R), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .ce(ce), .swap(swap),
        .req_op(req_op), .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
        .op(op), .op_valid(op_valid), .op_ready(op_ready),
        .frame_done(frame_done), .overrun(overrun), .cur_req(cur_req)
    );

    gpu_op_scheduler #(.REQUESTERS(R), .TIMEOUT_CYCLES(2)) dut_t2 (
        .clk(clk), .rst(rst), .ce(ce), .swap(swap),
        .req_op(req_op), .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready2),
        .op(op2), .op_valid(op_valid2), .op_ready(op_ready),
        .frame_done(frame_done2), .overrun(overrun2), .cur_req(cur_req2)
    );

    always #5 clk = ~clk;

    // Producer contents and bench-side frame model
    logic [15:0] ops [R][MAXOPS];
    int          n_ops [R];
    int          ptr [R];
    bit          silent [R];
    int          ce_mode, ready_mode, gap_pct, cyc;
    bit          chk_t2;
    int          m_cur, m_idle;
    bit          m_done, m_ovr;
    logic [SW-1:0] exp_q[$];
    int          n_cmp, n_fail;
    string       cur_test;

    task automatic rebuild_exp();
        exp_q.delete();
        for (int i = 0; i < R; i++)
            for (int k = ptr[i]; k < n_ops[i]; k++)
                exp_q.push_back({i[1:0], ops[i][k]});
    endtask

    task automatic setup_frame(input int max_ops);
        for (int i = 0; i < R; i++) begin
            n_ops[i]  = $urandom_range(1, max_ops);
            ptr[i]    = 0;
            silent[i] = 1'b0;
            for (int k = 0; k < MAXOPS; k++) ops[i][k] = 16'($urandom);
        end
    endtask

    task automatic begin_frame();
        swap      = 1'b1;
        req_valid = '0;
        ce        = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        swap   = 1'b0;
        m_cur  = 0; m_idle = 0; m_done = 1'b0; m_ovr = 1'b0;
        cyc    = 0;
        rebuild_exp();
    endtask

    task automatic drive_inputs();
        case (ce_mode)
            0: ce = 1'b1;
            1: ce = ($urandom_range(0, 3) != 0);
            default: ce = (cyc % 4 == 0);
        endcase
        case (ready_mode)
            0: op_ready = 1'b1;
            1: op_ready = (cyc % 2 == 0);
            default: op_ready = 1'($urandom_range(0, 1));
        endcase
        for (int i = 0; i < R; i++) begin
            if (ptr[i] < n_ops[i]) begin
                req_op[i]    = ops[i][ptr[i]];
                req_last[i]  = (ptr[i] == n_ops[i] - 1);
                req_valid[i] = !silent[i] && ($urandom_range(0, 99) >= gap_pct);
            end else begin
                req_op[i]    = 16'($urandom);
                req_last[i]  = 1'b0;
                req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic check_and_update();
        logic          exp_valid;
        logic [R-1:0]  exp_ready;
        logic [SW-1:0] got, want;
        bit            acc;
        exp_valid = 1'b0;
        exp_ready = '0;
        if (!rst && !m_done) begin
            exp_valid = ce && req_valid[m_cur];
            exp_ready[m_cur] = ce && op_ready;
        end
        n_cmp++;
        if (op_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL %s op_valid cyc=%0d: got %b expected %b", cur_test, cyc, op_valid, exp_valid);
        end
        n_cmp++;
        if (req_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL %s req_ready cyc=%0d: got %b expected %b", cur_test, cyc, req_ready, exp_ready);
        end
        n_cmp++;
        if (frame_done !== m_done) begin
            n_fail++;
            $display("FAIL %s frame_done cyc=%0d: got %b expected %b", cur_test, cyc, frame_done, m_done);
        end
        n_cmp++;
        if (overrun !== m_ovr) begin
            n_fail++;
            $display("FAIL %s overrun cyc=%0d: got %b expected %b", cur_test, cyc, overrun, m_ovr);
        end
        if (!m_done) begin
            n_cmp++;
            if (cur_req !== m_cur[0:0]) begin
                n_fail++;
                $display("FAIL %s cur_req cyc=%0d: got %0d expected %0d", cur_test, cyc, cur_req, m_cur);
            end
        end
        if (chk_t2) begin
            n_cmp++;
            if (overrun2 !== 1'b0 || frame_done2 !== m_done || (!m_done && cur_req2 !== m_cur[0:0])) begin
                n_fail++;
                $display("FAIL %s t2_watchdog cyc=%0d: got cur=%0d ovr=%b done=%b expected cur=%0d ovr=0 done=%b",
                         cur_test, cyc, cur_req2, overrun2, frame_done2, m_cur, m_done);
            end
        end
        acc = exp_valid && op_ready;
        if (acc) begin
            got = {m_cur[1:0], op};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s op_data cyc=%0d: got %h expected nothing", cur_test, cyc, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL %s op_data cyc=%0d: got %h expected %h", cur_test, cyc, got, want);
                end
            end
            ptr[m_cur]++;
        end
        if (rst || swap) begin
            m_cur = 0; m_idle = 0; m_done = 1'b0; m_ovr = 1'b0;
            rebuild_exp();
        end else if (!m_done && ce) begin
            if (acc) begin
                m_idle = 0;
                if (req_last[m_cur]) begin
                    if (m_cur == R - 1) m_done = 1'b1;
                    else m_cur++;
                end
            end else if (req_valid[m_cur]) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == T) begin
                    while (exp_q.size() > 0 && exp_q[0][SW-1:16] == m_cur[1:0]) want = exp_q.pop_front();
                    m_ovr  = 1'b1;
                    m_idle = 0;
                    if (m_cur == R - 1) m_done = 1'b1;
                    else m_cur++;
                end
            end
        end
    endtask

    task automatic step();
        drive_inputs();
        @(negedge clk);
        check_and_update();
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic run_until_done(input int budget);
        int k;
        k = 0;
        while (!m_done && k < budget) begin
            step();
            k++;
        end
        if (!m_done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s frame_timeout: got no frame end after %0d cycles, expected frame end", cur_test, budget);
        end
        step();
        step();
    endtask

    task automatic test_reset();
        cur_test = "reset";
        ce_mode = 0; ready_mode = 0; gap_pct = 0; chk_t2 = 1'b0;
        rst = 1'b1; swap = 1'b0;
        setup_frame(4);
        m_cur = 0; m_idle = 0; m_done = 1'b0; m_ovr = 1'b0; cyc = 0;
        drive_inputs();
        @(posedge clk); #1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        cur_test = "basic";
        ce_mode = 0; ready_mode = 0; gap_pct = 0; chk_t2 = 1'b0;
        setup_frame(1);
        n_ops[0] = 3; n_ops[1] = 2;
        begin_frame();
        run_until_done(20);
    endtask

    task automatic test_ready_toggle();
        cur_test = "ready_toggle";
        ce_mode = 0; ready_mode = 1; gap_pct = 0; chk_t2 = 1'b1;
        setup_frame(MAXOPS);
        begin_frame();
        run_until_done(60);
        chk_t2 = 1'b0;
    endtask

    task automatic test_timeout();
        cur_test = "timeout";
        ce_mode = 0; ready_mode = 0; gap_pct = 0;
        setup_frame(4);
        silent[0] = 1'b1;
        begin_frame();
        run_until_done(40);
    endtask

    task automatic test_swap();
        int k;
        cur_test = "swap";
        ce_mode = 0; ready_mode = 0; gap_pct = 0;
        setup_frame(1);
        silent[0] = 1'b1;
        n_ops[1] = 6;
        begin_frame();
        k = 0;
        while (!(m_cur == 1 && ptr[1] == 2) && k < 40) begin
            step();
            k++;
        end
        n_cmp++;
        if (m_cur != 1 || ptr[1] != 2) begin
            n_fail++;
            $display("FAIL swap reach_req1: got cur=%0d sent=%0d, expected cur=1 sent=2", m_cur, ptr[1]);
        end
        swap = 1'b1;
        step();
        swap = 1'b0;
        run_until_done(40);
    endtask

    task automatic test_ce_gating();
        cur_test = "ce_gating";
        ce_mode = 2; ready_mode = 0; gap_pct = 0;
        setup_frame(MAXOPS);
        begin_frame();
        run_until_done(200);
        cur_test = "ce_gating_idle";
        setup_frame(3);
        silent[0] = 1'b1;
        begin_frame();
        run_until_done(200);
    endtask

    task automatic test_reset_in_done();
        cur_test = "reset_in_done";
        ce_mode = 0; ready_mode = 0; gap_pct = 0;
        setup_frame(3);
        silent[0] = 1'b1;
        begin_frame();
        run_until_done(40);
        setup_frame(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run_until_done(40);
    endtask

    task automatic test_random();
        for (int f = 0; f < 12; f++) begin
            cur_test = "random";
            ce_mode = 1; ready_mode = 2; gap_pct = 30;
            setup_frame(MAXOPS);
            for (int i = 0; i < R; i++) silent[i] = ($urandom_range(0, 4) == 0);
            begin_frame();
            run_until_done(400);
        end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; swap = 1'b0; op_ready = 1'b0;
        req_valid = '0; req_last = '0; req_op = '0;
        n_cmp = 0; n_fail = 0; chk_t2 = 1'b0; cyc = 0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_ready_toggle();
        test_timeout();
        test_swap();
        test_ce_gating();
        test_reset_in_done();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no end of run, expected completion");
        $fatal(1, "bench time limit reached");
    end

endmodule
